// File: rtl/mvb_rx_demux_if.sv
// MVB receive demux bus: upstream decoder strobes in, word/status out.
`timescale 1ns/1ps
interface mvb_rx_demux_if;
    logic        sd_det;
    logic        sd_master;
    logic [2:0]  len_code;
    logic        bit_in;
    logic        bit_valid;
    logic        nd_err;
    logic        ed_det;
    logic [15:0] word_out;
    logic        word_valid;
    logic [1:0]  sel;
    logic        is_master;
    logic        busy;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        fmt_err;

    // Upstream decoder side: drives symbol strobes, observes results.
    modport master (
        output sd_det, sd_master, len_code, bit_in, bit_valid, nd_err, ed_det,
        input  word_out, word_valid, sel, is_master, busy,
               frame_done, frame_ok, crc_err, fmt_err
    );

    // Demux side.
    modport slave (
        input  sd_det, sd_master, len_code, bit_in, bit_valid, nd_err, ed_det,
        output word_out, word_valid, sel, is_master, busy,
               frame_done, frame_ok, crc_err, fmt_err
    );
endinterface

// File: rtl/mvb_rx_demux.sv
// MVB frame receiver: splits decoded bits into 16-bit words, checks each
// CRC group's check byte and reports frame status.
`timescale 1ns/1ps
module mvb_rx_demux #(
    parameter int unsigned ED_TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_en,
    mvb_rx_demux_if.slave  bus
);
    localparam int unsigned TMR_W = $clog2(ED_TIMEOUT + 1);
    localparam logic [6:0]  POLY  = 7'h65;   // x^7+x^6+x^5+x^2+1

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_END} state_t;

    state_t             state_q, state_d;
    logic [15:0]        shift_q, shift_d;
    logic [15:0]        word_q, word_d;
    logic               word_valid_q, word_valid_d;
    logic [1:0]         sel_q, sel_d;
    logic               is_master_q, is_master_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ok_q, ok_d;
    logic               crc_err_q, crc_err_d;
    logic               fmt_err_q, fmt_err_d;
    logic               crc_flag_q, crc_flag_d;
    logic [6:0]         crc_q, crc_d;
    logic               par_q, par_d;
    logic [5:0]         grp_cnt_q, grp_cnt_d;
    logic [5:0]         grp_last_q, grp_last_d;
    logic [8:0]         bits_left_q, bits_left_d;
    logic [6:0]         chk_q, chk_d;
    logic [2:0]         chk_cnt_q, chk_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic               fin, fin_fmt, accept, fb;

    // Next-state, datapath and status computation.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        is_master_d  = is_master_q;
        done_d       = 1'b0;
        ok_d         = ok_q;
        crc_err_d    = crc_err_q;
        fmt_err_d    = fmt_err_q;
        crc_flag_d   = crc_flag_q;
        crc_d        = crc_q;
        par_d        = par_q;
        grp_cnt_d    = grp_cnt_q;
        grp_last_d   = grp_last_q;
        bits_left_d  = bits_left_q;
        chk_d        = chk_q;
        chk_cnt_d    = chk_cnt_q;
        timer_d      = timer_q;
        fin          = 1'b0;
        fin_fmt      = 1'b0;
        accept       = 1'b0;
        fb           = bus.bit_in ^ crc_q[6];

        if (!rx_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.sd_det) begin
                        is_master_d = bus.sd_master;
                        shift_d     = '0;
                        crc_d       = '0;
                        par_d       = 1'b0;
                        crc_flag_d  = 1'b0;
                        grp_cnt_d   = '0;
                        chk_cnt_d   = '0;
                        timer_d     = '0;
                        if (!bus.sd_master && bus.len_code > 3'd4) begin
                            fin     = 1'b1;
                            fin_fmt = 1'b1;
                        end else begin
                            accept      = 1'b1;
                            state_d     = S_DATA;
                            bits_left_d = bus.sd_master ? 9'd16 : (9'(16) << bus.len_code);
                            if (bus.sd_master || bus.len_code == 3'd0) begin
                                grp_last_d = 6'd15;
                            end else if (bus.len_code == 3'd1) begin
                                grp_last_d = 6'd31;
                            end else begin
                                grp_last_d = 6'd63;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (bus.nd_err || bus.sd_det) begin
                        fin     = 1'b1;
                        fin_fmt = 1'b1;
                    end else if (bus.bit_valid) begin
                        shift_d     = {shift_q[14:0], bus.bit_in};
                        crc_d       = {crc_q[5:0], 1'b0} ^ (fb ? POLY : 7'h00);
                        par_d       = par_q ^ bus.bit_in;
                        grp_cnt_d   = grp_cnt_q + 6'd1;
                        bits_left_d = bits_left_q - 9'd1;
                        if (grp_cnt_q[3:0] == 4'hF) begin
                            word_d       = shift_d;
                            word_valid_d = 1'b1;
                        end
                        if (grp_cnt_q == grp_last_q) begin
                            state_d   = S_CRC;
                            grp_cnt_d = '0;
                            chk_cnt_d = '0;
                        end
                    end
                end
                S_CRC: begin
                    if (bus.nd_err || bus.sd_det) begin
                        fin     = 1'b1;
                        fin_fmt = 1'b1;
                    end else if (bus.bit_valid) begin
                        chk_d     = {chk_q[5:0], bus.bit_in};
                        chk_cnt_d = chk_cnt_q + 3'd1;
                        if (chk_cnt_q == 3'd7) begin
                            // Check byte is the inverted {crc7, even parity over data+crc7}.
                            if ({chk_q, bus.bit_in} != ~{crc_q, ^crc_q ^ par_q}) begin
                                crc_flag_d = 1'b1;
                            end
                            crc_d   = '0;
                            par_d   = 1'b0;
                            timer_d = '0;
                            state_d = (bits_left_q == 9'd0) ? S_END : S_DATA;
                        end
                    end
                end
                S_END: begin
                    if (bus.nd_err || bus.sd_det || bus.bit_valid) begin
                        fin     = 1'b1;
                        fin_fmt = 1'b1;
                    end else if (bus.ed_det) begin
                        fin = 1'b1;
                    end else if (timer_q == TMR_W'(ED_TIMEOUT - 1)) begin
                        fin     = 1'b1;
                        fin_fmt = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (fin) begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                fmt_err_d = fin_fmt;
                crc_err_d = crc_flag_d;
                ok_d      = ~crc_flag_d & ~fin_fmt;
            end
        end

        case (state_d)
            S_DATA:  sel_d = 2'b10;
            S_CRC:   sel_d = 2'b11;
            S_END:   sel_d = 2'b01;
            default: sel_d = 2'b00;
        endcase
        if (accept) sel_d = 2'b01;
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            sel_q        <= 2'b00;
            is_master_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            crc_err_q    <= 1'b0;
            fmt_err_q    <= 1'b0;
            crc_flag_q   <= 1'b0;
            crc_q        <= '0;
            par_q        <= 1'b0;
            grp_cnt_q    <= '0;
            grp_last_q   <= '0;
            bits_left_q  <= '0;
            chk_q        <= '0;
            chk_cnt_q    <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            sel_q        <= sel_d;
            is_master_q  <= is_master_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            crc_err_q    <= crc_err_d;
            fmt_err_q    <= fmt_err_d;
            crc_flag_q   <= crc_flag_d;
            crc_q        <= crc_d;
            par_q        <= par_d;
            grp_cnt_q    <= grp_cnt_d;
            grp_last_q   <= grp_last_d;
            bits_left_q  <= bits_left_d;
            chk_q        <= chk_d;
            chk_cnt_q    <= chk_cnt_d;
            timer_q      <= timer_d;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.sel        = sel_q;
    assign bus.is_master  = is_master_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.frame_ok   = ok_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.fmt_err    = fmt_err_q;
endmodule

// File: tb/tb_mvb_rx_demux.sv
// Directed self-checking bench for mvb_rx_demux.
`timescale 1ns/1ps
module tb_mvb_rx_demux;
    logic clk = 1'b0;
    logic rst;
    logic rx_en;
    always #5 clk = ~clk;

    mvb_rx_demux_if bus ();
    mvb_rx_demux #(.ED_TIMEOUT(32)) dut (.clk(clk), .rst(rst), .rx_en(rx_en), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Observed activity, collected on the falling edge.
    logic [15:0] words[$];
    logic [1:0]  sels[$];
    logic [1:0]  prev_sel = 2'b00;
    int          done_cnt = 0;
    logic        last_ok, last_crc, last_fmt;
    logic        grp_bits[$];

    always @(negedge clk) begin
        if (bus.word_valid === 1'b1) words.push_back(bus.word_out);
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            last_ok  = bus.frame_ok;
            last_crc = bus.crc_err;
            last_fmt = bus.fmt_err;
        end
        if (bus.sel !== prev_sel) begin
            sels.push_back(bus.sel);
            prev_sel = bus.sel;
        end
    end

    // Reference check byte: long-division CRC7 plus even parity, inverted.
    function automatic logic [7:0] check_byte(input logic d[$]);
        logic       m[$];
        logic [7:0] g;
        logic [6:0] c;
        logic       p;
        int         n;
        g = 8'b1110_0101;
        m = d;
        n = d.size();
        for (int k = 0; k < 7; k++) m.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (m[i]) for (int j = 0; j < 8; j++) m[i+j] = m[i+j] ^ g[7-j];
        for (int k = 0; k < 7; k++) c[6-k] = m[n+k];
        p = ^c;
        for (int i = 0; i < n; i++) p = p ^ d[i];
        return ~{c, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        words.delete();
        sels.delete();
        done_cnt = 0;
    endtask

    task automatic send_sd(input logic master, input logic [2:0] len);
        grp_bits.delete();
        bus.sd_det = 1'b1; bus.sd_master = master; bus.len_code = len;
        tick();
        bus.sd_det = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in = b; bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i]);
            grp_bits.push_back(w[i]);
        end
    endtask

    task automatic send_check(input logic [7:0] flip);
        logic [7:0] cb;
        cb = check_byte(grp_bits) ^ flip;
        for (int i = 7; i >= 0; i--) send_bit(cb[i]);
        grp_bits.delete();
    endtask

    task automatic send_ed();
        bus.ed_det = 1'b1;
        tick();
        bus.ed_det = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_en = 1'b1;
        bus.sd_det = 1'b1; bus.sd_master = 1'b1; bus.len_code = 3'd0;
        bus.bit_in = 1'b1; bus.bit_valid = 1'b1; bus.nd_err = 1'b0; bus.ed_det = 1'b1;
        tick(); tick();
        n_checks++; if (bus.sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b exp 00", bus.sel); end
        n_checks++; if (bus.word_out !== 16'h0) begin n_fail++; $display("FAIL reset_word: got %h exp 0000", bus.word_out); end
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wv: got %b exp 0", bus.word_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus.frame_done); end
        n_checks++; if (bus.is_master !== 1'b0) begin n_fail++; $display("FAIL reset_master: got %b exp 0", bus.is_master); end
        n_checks++; if ({bus.frame_ok, bus.crc_err, bus.fmt_err} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b exp 000", {bus.frame_ok, bus.crc_err, bus.fmt_err}); end
        bus.sd_det = 1'b0; bus.bit_valid = 1'b0; bus.ed_det = 1'b0; bus.bit_in = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_master();
        clear_mon();
        send_sd(1'b1, 3'd0);
        send_word(16'hA5C3);
        send_check(8'h00);
        send_ed();
        settle();
        n_checks++; if (words.size() !== 1) begin n_fail++; $display("FAIL master_wcount: got %0d exp 1", words.size()); end
        n_checks++; if (words.size() > 0 && words[0] !== 16'hA5C3) begin n_fail++; $display("FAIL master_word: got %h exp a5c3", words[0]); end
        n_checks++; if (bus.word_out !== 16'hA5C3) begin n_fail++; $display("FAIL master_hold: got %h exp a5c3", bus.word_out); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL master_done: got %0d exp 1", done_cnt); end
        n_checks++; if ({last_ok, last_crc, last_fmt} !== 3'b100) begin n_fail++; $display("FAIL master_status: got %b exp 100", {last_ok, last_crc, last_fmt}); end
        n_checks++; if (bus.is_master !== 1'b1) begin n_fail++; $display("FAIL master_ismaster: got %b exp 1", bus.is_master); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL master_busy: got %b exp 0", bus.busy); end
    endtask

    task automatic test_slave128(input logic [7:0] flip, input logic [2:0] exp_status, input string tag);
        logic [15:0] pat [8];
        logic [1:0]  exp_sel [7];
        pat[0] = 16'h1234; pat[1] = 16'hFFFF; pat[2] = 16'h0000; pat[3] = 16'h8001;
        pat[4] = 16'hDEAD; pat[5] = 16'hBEEF; pat[6] = 16'h5555; pat[7] = 16'hC0DE;
        exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11; exp_sel[3] = 2'b10;
        exp_sel[4] = 2'b11; exp_sel[5] = 2'b01; exp_sel[6] = 2'b00;
        clear_mon();
        send_sd(1'b0, 3'd3);
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 4; k++) send_word(pat[g*4+k]);
            send_check((g == 1) ? flip : 8'h00);
        end
        send_ed();
        settle();
        n_checks++; if (words.size() !== 8) begin n_fail++; $display("FAIL %s_wcount: got %0d exp 8", tag, words.size()); end
        for (int i = 0; i < 8 && i < words.size(); i++) begin
            n_checks++; if (words[i] !== pat[i]) begin n_fail++; $display("FAIL %s_word%0d: got %h exp %h", tag, i, words[i], pat[i]); end
        end
        n_checks++; if (sels.size() !== 7) begin n_fail++; $display("FAIL %s_selcount: got %0d exp 7", tag, sels.size()); end
        for (int i = 0; i < 7 && i < sels.size(); i++) begin
            n_checks++; if (sels[i] !== exp_sel[i]) begin n_fail++; $display("FAIL %s_sel%0d: got %b exp %b", tag, i, sels[i], exp_sel[i]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done: got %0d exp 1", tag, done_cnt); end
        n_checks++; if ({last_ok, last_crc, last_fmt} !== exp_status) begin n_fail++; $display("FAIL %s_status: got %b exp %b", tag, {last_ok, last_crc, last_fmt}, exp_status); end
        n_checks++; if (bus.is_master !== 1'b0) begin n_fail++; $display("FAIL %s_ismaster: got %b exp 0", tag, bus.is_master); end
    endtask

    task automatic test_illegal_len();
        clear_mon();
        send_sd(1'b0, 3'd6);
        n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL illegal_done: got %b exp 1", bus.frame_done); end
        n_checks++; if ({bus.frame_ok, bus.crc_err, bus.fmt_err} !== 3'b001) begin n_fail++; $display("FAIL illegal_status: got %b exp 001", {bus.frame_ok, bus.crc_err, bus.fmt_err}); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy: got %b exp 0", bus.busy); end
        tick();
        settle();
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL illegal_dcount: got %0d exp 1", done_cnt); end
    endtask

    task automatic test_nd_err();
        clear_mon();
        send_sd(1'b1, 3'd0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        bus.nd_err = 1'b1; bus.bit_in = 1'b1; bus.bit_valid = 1'b1;
        tick();
        bus.nd_err = 1'b0; bus.bit_valid = 1'b0;
        repeat (40) tick();
        settle();
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL nderr_done: got %0d exp 1", done_cnt); end
        n_checks++; if ({last_ok, last_crc, last_fmt} !== 3'b001) begin n_fail++; $display("FAIL nderr_status: got %b exp 001", {last_ok, last_crc, last_fmt}); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL nderr_busy: got %b exp 0", bus.busy); end
        n_checks++; if (words.size() !== 0) begin n_fail++; $display("FAIL nderr_words: got %0d exp 0", words.size()); end
    endtask

    task automatic test_timeout();
        int cnt;
        clear_mon();
        send_sd(1'b1, 3'd0);
        send_word(16'h0F0F);
        send_check(8'h00);
        cnt = 0;
        while (cnt < 100) begin
            tick();
            cnt++;
            if (bus.frame_done === 1'b1) break;
        end
        n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL timeout_cycles: got %0d exp 32", cnt); end
        n_checks++; if ({bus.frame_ok, bus.crc_err, bus.fmt_err} !== 3'b001) begin n_fail++; $display("FAIL timeout_status: got %b exp 001", {bus.frame_ok, bus.crc_err, bus.fmt_err}); end
        tick();
    endtask

    task automatic test_sd_abort();
        clear_mon();
        send_sd(1'b1, 3'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_sd(1'b0, 3'd0);
        settle();
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL abort_done: got %0d exp 1", done_cnt); end
        n_checks++; if (last_fmt !== 1'b1) begin n_fail++; $display("FAIL abort_fmt: got %b exp 1", last_fmt); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", bus.busy); end
    endtask

    task automatic test_rx_en_drop();
        clear_mon();
        send_sd(1'b0, 3'd1);
        for (int i = 0; i < 20; i++) send_bit(i[1]);
        rx_en = 1'b0;
        tick();
        rx_en = 1'b1;
        tick();
        settle();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rxen_busy: got %b exp 0", bus.busy); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rxen_done: got %0d exp 0", done_cnt); end
        n_checks++; if (words.size() !== 1) begin n_fail++; $display("FAIL rxen_words: got %0d exp 1", words.size()); end
        n_checks++; if (words.size() > 0 && words[0] !== 16'h3333) begin n_fail++; $display("FAIL rxen_word: got %h exp 3333", words[0]); end
    endtask

    task automatic test_rst_in_crc();
        clear_mon();
        send_sd(1'b1, 3'd0);
        send_word(16'h5A5A);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        n_checks++; if (bus.sel !== 2'b11) begin n_fail++; $display("FAIL rstcrc_insel: got %b exp 11", bus.sel); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.sel !== 2'b00) begin n_fail++; $display("FAIL rstcrc_sel: got %b exp 00", bus.sel); end
        n_checks++; if (bus.word_out !== 16'h0) begin n_fail++; $display("FAIL rstcrc_word: got %h exp 0000", bus.word_out); end
        n_checks++; if ({bus.busy, bus.is_master, bus.word_valid, bus.frame_done} !== 4'b0000) begin n_fail++; $display("FAIL rstcrc_flags: got %b exp 0000", {bus.busy, bus.is_master, bus.word_valid, bus.frame_done}); end
        n_checks++; if ({bus.frame_ok, bus.crc_err, bus.fmt_err} !== 3'b000) begin n_fail++; $display("FAIL rstcrc_status: got %b exp 000", {bus.frame_ok, bus.crc_err, bus.fmt_err}); end
        tick();
        clear_mon();
        send_sd(1'b1, 3'd0);
        send_word(16'h3C96);
        send_check(8'h00);
        send_ed();
        settle();
        n_checks++; if (words.size() !== 1 || words[0] !== 16'h3C96) begin n_fail++; $display("FAIL rstcrc_newword: got %0d words, first %h exp 1 word 3c96", words.size(), (words.size() > 0) ? words[0] : 16'hxxxx); end
        n_checks++; if (done_cnt !== 1 || {last_ok, last_crc, last_fmt} !== 3'b100) begin n_fail++; $display("FAIL rstcrc_newframe: got done %0d status %b exp 1 100", done_cnt, {last_ok, last_crc, last_fmt}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_master();
        test_slave128(8'h00, 3'b100, "slave_good");
        test_slave128(8'h01, 3'b010, "slave_crc");
        test_illegal_len();
        test_nd_err();
        test_timeout();
        test_sd_abort();
        test_rx_en_drop();
        test_rst_in_crc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mvb_rx_demux.md
MVB_RX_DEMUX -- requirements
Module: mvb_rx_demux

Interface
REQ-001 Parameter: ED_TIMEOUT, default 32, max clk cycles in END state awaiting the end delimiter.
REQ-002 Port: clk  in  1  single clock, all logic rising-edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: rx_en  in  1  block enable; 0 forces IDLE next cycle, no status pulses.
REQ-005 Port: sd_det  in  1  one-cycle pulse, start delimiter recognised upstream.
REQ-006 Port: sd_master  in  1  qualifies sd_det: 1 = master frame, 0 = slave frame.
REQ-007 Port: len_code  in  3  slave data length, sampled on sd_det: 0=16, 1=32, 2=64, 3=128, 4=256 bits; 5-7 illegal.
REQ-008 Port: bit_in  in  1  decoded Manchester data bit, MSB first.
REQ-009 Port: bit_valid  in  1  bit_in strobe, at most one per cycle.
REQ-010 Port: nd_err  in  1  pulse, non-data symbol or Manchester violation inside the frame.
REQ-011 Port: ed_det  in  1  pulse, end delimiter recognised.
REQ-012 Port: word_out  out  16  received data word, MSB = first bit.
REQ-013 Port: word_valid  out  1  one-cycle strobe, word_out valid.
REQ-014 Port: sel  out  2  current field: 00 idle, 01 delimiter, 10 data, 11 CRC (same coding as transmit side).
REQ-015 Port: is_master  out  1  frame type latched at sd_det.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: frame_done  out  1  one-cycle pulse, frame terminated (good or bad).
REQ-018 Port: frame_ok  out  1  valid with frame_done: 1 = no CRC or format error.
REQ-019 Port: crc_err  out  1  valid with frame_done: at least one check sequence mismatched.
REQ-020 Port: fmt_err  out  1  valid with frame_done: illegal length, nd_err, timeout or bit after final CRC.

Function
REQ-021 States IDLE, DATA, CRC, END; sel = 00, 10, 11, 01 respectively; sel = 01 also for the cycle sd_det is accepted.
REQ-022 IDLE: sd_det with rx_en=1 -> DATA; latch is_master, group and bit counters cleared, CRC register cleared.
REQ-023 Frame length: master = 16 bits; slave per len_code; illegal len_code -> immediate frame_done with fmt_err=1, next state IDLE.
REQ-024 DATA: each bit_valid shifts bit_in into 16-bit shifter and CRC; every 16th bit -> word_valid the following cycle, word_out held until next word.
REQ-025 CRC group = min(frame length, 64) data bits; after a group's last data bit -> CRC state.
REQ-026 CRC state: collect 8 bits; check sequence = 7-bit CRC, poly x^7+x^6+x^5+x^2+1, seed 0, plus even parity over data+CRC7, all 8 bits inverted.
REQ-027 Mismatch sets sticky crc_err flag; CRC register re-cleared; if more data remains -> DATA, else -> END.
REQ-028 END: ed_det -> frame_done; bit_valid or ED_TIMEOUT cycles without ed_det -> frame_done with fmt_err=1.
REQ-029 nd_err in DATA/CRC/END -> frame_done with fmt_err=1 next cycle, -> IDLE.
REQ-030 sd_det while busy: current frame aborted with frame_done, fmt_err=1; new frame not started.
REQ-031 frame_ok = ~crc_err & ~fmt_err; status outputs held until next frame_done.
REQ-032 Simultaneous bit_valid and nd_err: nd_err wins, bit discarded.
REQ-033 rx_en deassert mid-frame: -> IDLE, no frame_done, partial word discarded.

Reset
REQ-034 rst=1 on a clock edge: state IDLE, sel=00, word_out=0, all strobes 0, is_master=0, frame_ok/crc_err/fmt_err=0, counters 0; rst overrides all inputs.

Verification
REQ-035 Master frame, 16 bits 0xA5C3 + correct check byte + ed_det -> word_valid once with 0xA5C3, frame_done, frame_ok=1.
REQ-036 Slave len_code=3 (128 bits), correct check bytes -> 8 word_valid, sel 10/11 sequence twice, frame_ok=1.
REQ-037 Same as 036, second check byte bit flipped -> frame_done, crc_err=1, fmt_err=0, frame_ok=0.
REQ-038 len_code=6 -> frame_done within 1 cycle of sd_det, fmt_err=1.
REQ-039 nd_err mid-DATA, then no ed_det for 40 cycles -> single frame_done with fmt_err=1, busy=0.
REQ-040 rst asserted in CRC state -> next cycle all outputs at reset values, later sd_det starts clean frame.
